// File: rtl/prio_extint_controller.sv
// Fixed-priority external interrupt controller: per-source enable/mode, W1C pending,
// one-deep in-service tracking with a claim register readable over a simple word bus.
module prio_extint_controller #(
  parameter int SRC_NUM = 8,
  parameter int AW      = 4,
  parameter int BW      = 32
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               ext_int_trigger,
  input  logic               ext_int_handled,
  input  logic [SRC_NUM-1:0] ext_int_from,
  input  logic [AW-1:0]      addr,
  input  logic               w_rb,
  input  logic [1:0]         acc,
  output logic [BW-1:0]      rdata,
  input  logic [BW-1:0]      wdata,
  input  logic               req,
  output logic               resp,
  output logic               fault
);
  localparam int IDW = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam logic [1:0] ACC_4B = 2'b10;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state, state_nxt;
  logic [SRC_NUM-1:0] pend, enable, mode, prev;
  logic [SRC_NUM-1:0] edg, clr, eligible, pend_nxt;
  logic [IDW-1:0]     cur_id, winner;
  logic [1:0]         word;
  logic               invalid, valid, wr;
  logic [BW-1:0]      rd_val;

  assign word     = addr[3:2];
  assign invalid  = (acc != ACC_4B) || (addr[1:0] != 2'b00) || (32'(addr) > 32'hC) ||
                    (w_rb && word == 2'd3);
  assign fault    = req & invalid;
  assign valid    = req & ~invalid;
  assign wr       = valid & w_rb;
  assign eligible = pend & enable;
  assign edg      = ext_int_from & ~prev;
  assign ext_int_trigger = (state == ACTIVE);

  // Clear sources only matter for edge-mode bits; level bits mirror the line.
  always_comb begin
    clr = '0;
    if (wr && word == 2'd0)
      clr = wdata[SRC_NUM-1:0];
    if (state == ACTIVE && ext_int_handled)
      clr = clr | (SRC_NUM'(1) << cur_id);
    pend_nxt = (mode & ext_int_from) | (~mode & ((pend & ~clr) | edg));
  end

  always_comb begin
    winner = '0;
    for (int i = SRC_NUM - 1; i >= 0; i--)
      if (eligible[i]) winner = IDW'(i);
  end

  always_comb begin
    rd_val = '0;
    case (word)
      2'd0:    rd_val = BW'(pend);
      2'd1:    rd_val = BW'(enable);
      2'd2:    rd_val = BW'(mode);
      default: rd_val = (state == ACTIVE) ? BW'({1'b0, cur_id}) + BW'(1) : '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|eligible) state_nxt = ACTIVE;
      default: if (ext_int_handled) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend   <= '0;
      enable <= '1;
      mode   <= '0;
      prev   <= '0;
      cur_id <= '0;
      resp   <= 1'b0;
      rdata  <= '0;
    end else begin
      prev <= ext_int_from;
      pend <= pend_nxt;
      resp <= valid;
      if (valid && !w_rb)     rdata  <= rd_val;
      if (wr && word == 2'd1) enable <= wdata[SRC_NUM-1:0];
      if (wr && word == 2'd2) mode   <= wdata[SRC_NUM-1:0];
      if (state == IDLE && |eligible) cur_id <= winner;
    end
  end

  // Write-data bits above the source count are architecturally ignored.
  generate
    if (BW > SRC_NUM) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^wdata[BW-1:SRC_NUM];
    end
  endgenerate
endmodule

// File: tb/tb_prio_extint_controller.sv
// Directed + random bench for prio_extint_controller against a spec-level model.
module tb_prio_extint_controller;
  localparam int N = 8, AW = 5, BW = 32;
  localparam logic [AW-1:0] A_PEND = 5'h0, A_EN = 5'h4, A_MODE = 5'h8, A_CLAIM = 5'hC;

  logic clk = 1'b0, rstn = 1'b0;
  logic trig, handled = 1'b0;
  logic [N-1:0] from = '0;
  logic [AW-1:0] addr = '0;
  logic w_rb = 1'b0, req = 1'b0, resp, fault;
  logic [1:0] acc = 2'd2;
  logic [BW-1:0] rdata, wdata = '0;

  int checks = 0, errors = 0;
  logic [N-1:0] m_pend, m_en, m_mode, m_prev;
  bit m_act, m_resp;
  int m_cur;
  logic [31:0] m_rdata;
  logic fault_seen;

  always #5 clk = ~clk;

  prio_extint_controller #(.SRC_NUM(N), .AW(AW), .BW(BW)) dut (
    .clk(clk), .rstn(rstn), .ext_int_trigger(trig), .ext_int_handled(handled),
    .ext_int_from(from), .addr(addr), .w_rb(w_rb), .acc(acc), .rdata(rdata),
    .wdata(wdata), .req(req), .resp(resp), .fault(fault));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_inv();
    return (acc != 2'd2) || (addr[1:0] != 2'b00) || (int'(addr) > 12) ||
           (w_rb && int'(addr) == 12);
  endfunction

  function automatic logic [31:0] m_read(int off);
    case (off)
      0: return 32'(m_pend);
      4: return 32'(m_en);
      8: return 32'(m_mode);
      default: return m_act ? 32'(m_cur + 1) : 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_pend = '0; m_en = '1; m_mode = '0; m_prev = '0;
    m_act = 0; m_cur = 0; m_resp = 0; m_rdata = '0;
  endtask

  // Applies the rules for one clock edge using the inputs present before it.
  task automatic model_edge();
    logic [N-1:0] nxt;
    int e;
    bit valid;
    valid = req && !m_inv();
    if (!rstn) begin
      m_reset();
      return;
    end
    if (valid && !w_rb) m_rdata = m_read(int'(addr));
    m_resp = valid;
    for (int i = 0; i < N; i++) begin
      bit rose, cleared;
      rose    = from[i] && !m_prev[i];
      cleared = (valid && w_rb && addr == A_PEND && wdata[i]) || (m_act && handled && m_cur == i);
      if (m_mode[i]) nxt[i] = from[i];
      else           nxt[i] = rose ? 1'b1 : (cleared ? 1'b0 : m_pend[i]);
    end
    e = int'(m_pend & m_en);
    if (m_act) begin
      if (handled) m_act = 0;
    end else if (e != 0) begin
      m_act = 1;
      m_cur = $clog2(e & -e);
    end
    if (valid && w_rb && addr == A_EN)   m_en   = wdata[N-1:0];
    if (valid && w_rb && addr == A_MODE) m_mode = wdata[N-1:0];
    m_pend = nxt;
    m_prev = from;
  endtask

  task automatic cyc();
    @(negedge clk);
    fault_seen = fault;
    chk("fault", 32'(fault), 32'(req && m_inv()));
    @(posedge clk);
    model_edge();
    #1;
    chk("trigger", 32'(trig), 32'(m_act));
    chk("resp", 32'(resp), 32'(m_resp));
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic bus(bit w, logic [AW-1:0] a, logic [31:0] d, logic [1:0] ac);
    req = 1'b1; w_rb = w; addr = a; wdata = d; acc = ac;
    cyc();
    req = 1'b0; w_rb = 1'b0; acc = 2'd2;
  endtask

  task automatic wr(logic [AW-1:0] a, logic [31:0] d);
    bus(1'b1, a, d, 2'd2);
  endtask

  task automatic rd(string tag, logic [AW-1:0] a, logic [31:0] exp);
    bus(1'b0, a, 32'd0, 2'd2);
    chk(tag, rdata, exp);
  endtask

  task automatic pulse();
    handled = 1'b1; cyc(); handled = 1'b0;
  endtask

  task automatic bad(string tag, bit w, logic [AW-1:0] a, logic [1:0] ac);
    bus(w, a, 32'h0, ac);
    chk({tag, "_fault"}, 32'(fault_seen), 32'd1);
    chk({tag, "_resp"}, 32'(resp), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'hFF);
  endtask

  initial begin
    m_reset();
    cyc(); cyc();
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rstn = 1'b1; cyc();
    rd("rst_en", A_EN, 32'hFF);
    rd("rst_mode", A_MODE, 32'h0);
    rd("rst_pend", A_PEND, 32'h0);
    rd("rst_claim", A_CLAIM, 32'h0);

    // single edge source
    from = 8'h08; cyc();
    chk("t1_trig_k", 32'(trig), 32'd0);
    cyc();
    chk("t1_trig_k1", 32'(trig), 32'd1);
    rd("t1_pend", A_PEND, 32'h08);
    rd("t1_claim", A_CLAIM, 32'd4);
    from = '0; pulse();
    chk("t1_trig_off", 32'(trig), 32'd0);
    rd("t1_pend_clr", A_PEND, 32'h0);

    // simultaneous edges: priority then mandatory idle gap
    from = 8'h24; cyc(); cyc();
    rd("t2_claim_a", A_CLAIM, 32'd3);
    pulse();
    chk("t2_idle_gap", 32'(trig), 32'd0);
    cyc();
    chk("t2_retrig", 32'(trig), 32'd1);
    rd("t2_claim_b", A_CLAIM, 32'd6);
    pulse(); from = '0;

    // enable masking and W1C
    wr(A_EN, 32'hFE);
    from = 8'h01; cyc(); cyc();
    chk("t3_masked", 32'(trig), 32'd0);
    rd("t3_pend", A_PEND, 32'h01);
    wr(A_EN, 32'hFF); cyc();
    chk("t3_unmasked", 32'(trig), 32'd1);
    pulse(); from = '0;
    wr(A_EN, 32'h0);
    from = 8'h01; cyc(); cyc();
    rd("t3_pend2", A_PEND, 32'h01);
    wr(A_PEND, 32'h01);
    rd("t3_w1c", A_PEND, 32'h0);
    wr(A_EN, 32'hFF); cyc();
    chk("t3_no_trig", 32'(trig), 32'd0);
    from = '0;

    // level mode re-claim
    wr(A_MODE, 32'h02);
    from = 8'h02; cyc(); cyc();
    rd("t4_claim", A_CLAIM, 32'd2);
    pulse();
    chk("t4_gap", 32'(trig), 32'd0);
    cyc();
    chk("t4_reclaim", 32'(trig), 32'd1);
    rd("t4_claim2", A_CLAIM, 32'd2);
    from = '0; cyc();
    rd("t4_pend_lvl", A_PEND, 32'h0);
    chk("t4_hold", 32'(trig), 32'd1);
    pulse(); cyc();
    chk("t4_no_retrig", 32'(trig), 32'd0);
    wr(A_MODE, 32'h0);

    // invalid accesses
    rd("t5_pre", A_EN, 32'hFF);
    bad("t5_acc", 1'b0, A_EN, 2'd1);
    bad("t5_mis", 1'b0, 5'h02, 2'd2);
    bad("t5_oor", 1'b0, 5'h10, 2'd2);
    bad("t5_wclaim", 1'b1, A_CLAIM, 2'd2);
    bad("t5_wacc", 1'b1, A_EN, 2'd0);
    rd("t5_en_kept", A_EN, 32'hFF);

    // set beats same-cycle W1C; reset while active
    wr(A_EN, 32'h0);
    from = 8'h10; cyc(); from = '0; cyc();
    from = 8'h10; wr(A_PEND, 32'h10);
    rd("t6_set_wins", A_PEND, 32'h10);
    wr(A_EN, 32'hFF); cyc();
    chk("t6_active", 32'(trig), 32'd1);
    rd("t6_claim", A_CLAIM, 32'd5);
    rstn = 1'b0; from = 8'h40; cyc();
    chk("t6_rst_trig", 32'(trig), 32'd0);
    cyc(); rstn = 1'b1; cyc();
    rd("t6_rel_edge", A_PEND, 32'h40);
    rd("t6_rst_en", A_EN, 32'hFF);
    rd("t6_rst_mode", A_MODE, 32'h0);
    rd("t6_claim_rel", A_CLAIM, 32'd7);
    pulse(); from = '0;

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(7) == 0) from = from ^ N'(1 << $urandom_range(N - 1));
      handled = ($urandom_range(3) == 0);
      rstn    = ($urandom_range(149) != 0);
      req     = ($urandom_range(1) == 1);
      w_rb    = ($urandom_range(2) == 0);
      addr    = ($urandom_range(9) == 0) ? AW'($urandom_range(31)) : AW'($urandom_range(3) * 4);
      acc     = ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'd2;
      wdata   = $urandom;
      cyc();
    end
    req = 1'b0; handled = 1'b0; rstn = 1'b1; cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prio_extint_controller.md
Name: prio_extint_controller

Overview:
- Parametrised external interrupt controller between peripheral IP interrupt lines and the core's single external-interrupt input.
- Per-source enable and edge/level mode, W1C pending register and fixed-priority arbitration (lowest index wins).
- A one-deep in-service tracker presents one interrupt at a time to the core and exposes its ID over the bus.

Parameters:
SRC_NUM, 8, number of interrupt sources (1..32)
AW, 4, bus address width in bits (byte address; 4 words decoded)
BW, 32, bus data width

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
ext_int_trigger  out  1  interrupt request to core; high while in-service
ext_int_handled  in  1  one-cycle pulse from core: current interrupt serviced
ext_int_from  in  SRC_NUM  raw interrupt lines from IP
addr  in  AW  bus byte address
w_rb  in  1  1=write, 0=read
acc  in  2  access size; only 4-byte accesses are valid
rdata  out  BW  read data, registered
wdata  in  BW  write data
req  in  1  bus request
resp  out  1  registered response, one cycle after a valid req
fault  out  1  combinational; equals req & invalid

Behaviour:
- Register map (word offsets):
  - 0x0 PENDING: read; write-1-to-clear, edge-mode bits only.
  - 0x4 ENABLE: read/write.
  - 0x8 MODE: read/write; 1=level, 0=rising edge.
  - 0xC CLAIM: read-only; returns cur_id+1 in ACTIVE, else 0.
  - Bits [BW-1:SRC_NUM] read 0 and ignore writes.
- Invalid access:
  - Any of: acc != 4B; addr[1:0] != 0; offset > 0xC; write to CLAIM.
  - Effect: fault=1 the same cycle, no resp, no state change, rdata unchanged.
- Valid access:
  - resp=1 on the next cycle.
  - Read: rdata updated on the same edge as resp; otherwise rdata holds.
  - Write: takes effect on the clock edge where req is sampled.
- Reset values: resp=0, rdata=0, ext_int_trigger=0, PENDING=0, ENABLE=all 1, MODE=0, prev-input reg=0, FSM=IDLE, cur_id=0.
- Edge detect:
  - prev <= ext_int_from each cycle; edge = ext_int_from & ~prev.
  - A line already high when reset is released counts as an edge in the first cycle.
- Pending, edge mode:
  - pend <= (pend & ~clr) | edge.
  - clr = W1C mask OR handled-clear of cur_id.
  - Set wins over a same-cycle clear.
- Pending, level mode: pend <= ext_int_from (one-cycle lag); W1C and handled have no effect.
- Mode change:
  - level->edge: pending bit keeps its value.
  - edge->level: pending bit tracks the input from the next cycle.
- Eligible = pend & ENABLE; winner = lowest set index.
- FSM:
  - IDLE: if any eligible, latch cur_id=winner and go to ACTIVE. ext_int_handled is ignored.
  - ACTIVE: ext_int_trigger=1. On ext_int_handled: clear pend[cur_id] (edge mode) and go to IDLE.
  - IDLE always lasts at least one cycle, so trigger drops for ≥1 cycle between interrupts.
- Latency: input rises before edge k -> pend=1 after edge k -> trigger=1 after edge k+1.
- While ACTIVE:
  - Disabling cur_id or level deassertion does not drop trigger; only handled or reset ends ACTIVE.
  - Higher-priority arrivals wait; there is no preemption.
- Level source still high after handled: re-pends and re-claims after the IDLE cycle.
- Reset mid-ACTIVE returns all state to reset values; trigger falls on the reset edge.

Test Plan:
- Edge on src 3 (ENABLE default) -> PENDING=0x08, trigger 2 cycles after the rise; CLAIM read=4; handled pulse -> PENDING=0x00, trigger low next cycle.
- Same-cycle edges on src 5 and 2 -> claim ID 3 first; after handled, one IDLE cycle (trigger=0), then claim ID 6.
- ENABLE=0xFE, edge on src 0 -> PENDING=0x01, no trigger. Write ENABLE=0xFF -> trigger; W1C 0x01 while IDLE with ENABLE=0 -> PENDING=0.
- MODE bit 1=1, hold src 1 high across handled -> re-trigger with CLAIM=2. Deassert src 1 -> PENDING bit clears one cycle later, with no re-trigger after handled.
- acc=2B read, addr=0x2, addr=0x10, write 0xC -> fault=1 in the same cycle, resp=0, registers and rdata unchanged.
- W1C of bit 4 in the same cycle as a new edge on src 4 -> PENDING bit 4 stays 1. Reset asserted while ACTIVE -> trigger=0 and all registers at reset values.
